// File: rtl/tile_buffer.sv
// First-word fall-through tile FIFO with per-entry end-of-transfer marker.
// Flags bad upstream behaviour (overflow, orphan load_done) as sticky bits until clear.
module tile_buffer #(
  parameter int TILE_WIDTH = 256,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [TILE_WIDTH-1:0]   tile_in,
  input  logic                    tile_valid,
  input  logic                    load_done,
  output logic [TILE_WIDTH-1:0]   out_tile,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    xfer_done,
  output logic                    overflow,
  output logic                    protocol_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic                  last;
    logic [TILE_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, drop;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_tile  = mem[rd_ptr].data;
  assign out_last  = mem[rd_ptr].last;

  // A full buffer still takes a push when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = tile_valid & (~full | pop);
  assign drop = tile_valid & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      xfer_done    <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      xfer_done    <= 1'b0;
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      xfer_done <= pop & mem[rd_ptr].last;
      if (drop)                     overflow     <= 1'b1;
      if (load_done && !tile_valid) protocol_err <= 1'b1;
    end
  end

  // Storage is never reset; out_valid qualifies whatever sits at the head.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= '{last: load_done, data: tile_in};
  end

endmodule

// File: tb/tb_tile_buffer.sv
// Bench for tile_buffer: fixed vector table, directed sequences and random traffic
// checked against a queue-based reference model.
module tb_tile_buffer;
  localparam int TW = 32;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, clear, tile_valid, load_done, out_ready;
  logic [TW-1:0] tile_in, out_tile;
  logic          out_valid, out_last, full, xfer_done, overflow, protocol_err;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  tile_buffer #(.TILE_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .tile_in(tile_in), .tile_valid(tile_valid),
    .load_done(load_done), .out_tile(out_tile), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .count(count), .full(full), .xfer_done(xfer_done),
    .overflow(overflow), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr, tv, ld, rdy;
    logic [TW-1:0] din;
    logic [CW-1:0] cnt;
    logic vld;
    logic [TW-1:0] tile;
    logic last, xd, ov, pe;
  } vec_t;

  typedef struct {
    logic          last;
    logic [TW-1:0] data;
  } ent_t;

  // Reference state: a plain queue of tiles plus the three flags.
  ent_t q[$];
  logic m_xd, m_ov, m_pe;

  function automatic vec_t mk(logic clr, logic tv, logic ld, logic rdy, logic [TW-1:0] din,
                              logic [CW-1:0] cnt, logic vld, logic [TW-1:0] tile,
                              logic last, logic xd, logic ov, logic pe);
    vec_t v;
    v.clr = clr; v.tv = tv; v.ld = ld; v.rdy = rdy; v.din = din;
    v.cnt = cnt; v.vld = vld; v.tile = tile; v.last = last; v.xd = xd; v.ov = ov; v.pe = pe;
    return v;
  endfunction

  task automatic cmp(string tag, logic [CW-1:0] ecnt, logic evld, logic [TW-1:0] etile,
                     logic elast, logic exd, logic eov, logic epe);
    logic efull, ok;
    efull = (ecnt == CW'(DEPTH));
    vectors++;
    ok = (count == ecnt) && (full == efull) && (out_valid == evld) && (xfer_done == exd) &&
         (overflow == eov) && (protocol_err == epe) &&
         (!evld || (out_tile == etile && out_last == elast));
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d full=%b vld=%b tile=%h last=%b xd=%b ov=%b pe=%b; want cnt=%0d full=%b vld=%b tile=%h last=%b xd=%b ov=%b pe=%b",
               tag, count, full, out_valid, out_tile, out_last, xfer_done, overflow, protocol_err,
               ecnt, efull, evld, etile, elast, exd, eov, epe);
    end
  endtask

  task automatic drive(logic clr, logic tv, logic ld, logic rdy, logic [TW-1:0] din);
    clear = clr; tile_valid = tv; load_done = ld; out_ready = rdy; tile_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_xd = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
  endtask

  // One cycle through both the DUT and the reference, then compare.
  task automatic mstep(string tag, logic clr, logic tv, logic ld, logic rdy, logic [TW-1:0] din);
    bit was_full, do_pop;
    ent_t e;
    if (clr) begin
      model_reset();
    end else begin
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && rdy;
      m_xd = do_pop && q[0].last;
      if (tv && was_full && !do_pop) m_ov = 1'b1;
      if (ld && !tv) m_pe = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (tv && (!was_full || do_pop)) begin
        e.last = ld; e.data = din;
        q.push_back(e);
      end
    end
    drive(clr, tv, ld, rdy, din);
    if (q.size() != 0) cmp(tag, CW'(q.size()), 1'b1, q[0].data, q[0].last, m_xd, m_ov, m_pe);
    else               cmp(tag, '0, 1'b0, '0, 1'b0, m_xd, m_ov, m_pe);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = mk(0,0,0,0, 32'h0,  0,0,32'h0, 0,0,0,0);
    tbl[1]  = mk(0,1,0,0, 32'hA0, 1,1,32'hA0,0,0,0,0);
    tbl[2]  = mk(0,1,1,0, 32'hB0, 2,1,32'hA0,0,0,0,0);
    tbl[3]  = mk(0,0,0,1, 32'h0,  1,1,32'hB0,1,0,0,0);
    tbl[4]  = mk(0,0,0,1, 32'h0,  0,0,32'h0, 0,1,0,0);
    tbl[5]  = mk(0,0,0,0, 32'h0,  0,0,32'h0, 0,0,0,0);
    tbl[6]  = mk(0,0,1,0, 32'h0,  0,0,32'h0, 0,0,0,1);
    tbl[7]  = mk(0,0,0,1, 32'h0,  0,0,32'h0, 0,0,0,1);
    tbl[8]  = mk(1,1,0,0, 32'hEE, 0,0,32'h0, 0,0,0,0);
    tbl[9]  = mk(0,1,0,1, 32'hC0, 1,1,32'hC0,0,0,0,0);
    tbl[10] = mk(1,0,0,1, 32'h0,  0,0,32'h0, 0,0,0,0);

    rst = 1'b0; clear = 1'b0; tile_valid = 1'b0; load_done = 1'b0; out_ready = 1'b0; tile_in = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].clr, tbl[i].tv, tbl[i].ld, tbl[i].rdy, tbl[i].din);
      cmp($sformatf("table[%0d]", i), tbl[i].cnt, tbl[i].vld, tbl[i].tile, tbl[i].last,
          tbl[i].xd, tbl[i].ov, tbl[i].pe);
    end
    model_reset();

    // A..D streamed with the consumer always ready; D closes the transfer.
    mstep("seq_a", 0,1,0,1, 32'hA);
    mstep("seq_b", 0,1,0,1, 32'hB);
    mstep("seq_c", 0,1,0,1, 32'hC);
    mstep("seq_d", 0,1,1,1, 32'hD);
    repeat (3) mstep("seq_drain", 0,0,0,1, 32'h0);

    // Overfill, then a push that rides on a same-cycle pop while full, then drain.
    for (int i = 1; i <= 9; i++) mstep($sformatf("fill%0d", i), 0,1,0,0, TW'(i));
    mstep("clr_ovf", 1,0,0,0, 32'h0);
    for (int i = 1; i <= 8; i++) mstep($sformatf("refill%0d", i), 0,1,0,0, TW'(i));
    mstep("full_pushpop", 0,1,0,1, 32'h99);
    for (int i = 0; i < 9; i++) mstep("drain", 0,0,0,1, 32'h0);

    // Sustained push/pop carries both pointers through the wrap.
    for (int i = 0; i < 20; i++) mstep("wrap", 0,1,(i % 5) == 4,(i > 2), TW'(32'h100 + i));
    repeat (4) mstep("wrap_drain", 0,0,0,1, 32'h0);

    // Orphan load_done, then clear wins over a concurrent push.
    mstep("orphan_ld", 0,0,1,0, 32'h0);
    mstep("clr_push", 1,1,0,0, 32'h55);

    // Reset mid-operation must empty the buffer without waiting for an edge.
    for (int i = 0; i < 3; i++) mstep("pre_rst", 0,1,0,0, TW'(32'h200 + i));
    #2;
    rst = 1'b0;
    #1;
    cmp("async_rst", '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    mstep("post_rst_push", 0,1,0,0, 32'h300);

    for (int i = 0; i < 400; i++)
      mstep("random", $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, TW'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tile_buffer.md
TILE_BUFFER -- requirements
Module: tile_buffer

Interface
REQ-001 SHALL have parameter TILE_WIDTH, default 256, tile width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of tile entries, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, sole clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous flush.
REQ-006 SHALL have port tile_in, input, TILE_WIDTH, tile data from the upstream loader.
REQ-007 SHALL have port tile_valid, input, 1, one-cycle strobe; tile_in is valid in that cycle.
REQ-008 SHALL have port load_done, input, 1, one-cycle upstream end-of-transfer strobe.
REQ-009 SHALL have port out_tile, output, TILE_WIDTH, head-entry data.
REQ-010 SHALL have port out_valid, output, 1, buffer non-empty.
REQ-011 SHALL have port out_last, output, 1, head entry is the last tile of a transfer.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries.
REQ-014 SHALL have port full, output, 1, count equals DEPTH.
REQ-015 SHALL have port xfer_done, output, 1, one-cycle pulse, registered.
REQ-016 SHALL have port overflow, output, 1, sticky flag.
REQ-017 SHALL have port protocol_err, output, 1, sticky flag.

Function
REQ-018 SHALL implement a circular buffer of DEPTH entries, each holding TILE_WIDTH data plus one last bit, with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-019 SHALL accept a push on tile_valid when not full, or when full with a pop in the same cycle.
REQ-020 SHALL set the stored last bit to 1 when load_done coincides with tile_valid, and to 0 otherwise.
REQ-021 SHALL pop when out_valid and out_ready are both 1; out_tile and out_last SHALL show entry rd_ptr combinationally (first-word fall-through).
REQ-022 SHALL make a pushed tile visible at out_valid one cycle after the push; empty-buffer latency is 1 cycle.
REQ-023 SHALL hold count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-024 SHALL drop tile_valid while full without a same-cycle pop, leave state unchanged, and set overflow.
REQ-025 SHALL treat load_done without tile_valid as no push and set protocol_err.
REQ-026 SHALL pulse xfer_done the cycle after a pop of an entry whose last bit is 1.
REQ-027 SHALL ignore out_ready while out_valid is 0.
REQ-028 SHALL, on clear, zero pointers, count, overflow and protocol_err, and drop any same-cycle push or pop; clear SHALL have priority over all other events.
REQ-029 SHALL not require entry contents to be cleared; out_tile is don't-care while out_valid is 0.

Reset
REQ-030 SHALL, while rst is 0, asynchronously force pointers, count, full, out_valid, xfer_done, overflow and protocol_err to 0.
REQ-031 SHALL abandon buffered contents on reset mid-operation and accept a push on the first clk edge after rst deasserts.

Verification
REQ-032 SHALL pass: 4 pushes (tiles A,B,C,D; load_done with D), out_ready=1 -> out_valid rises 1 cycle after A; pops in order A..D; out_last=1 only on D; xfer_done pulses once after D.
REQ-033 SHALL pass: DEPTH=8, 9 pushes with out_ready=0 -> full=1, count=8, overflow=1, 9th tile absent; draining yields tiles 1..8.
REQ-034 SHALL pass: full buffer, push and pop in the same cycle -> count stays 8, overflow stays 0, new tile appears after the 7 older tiles.
REQ-035 SHALL pass: 20 push/pop cycles at DEPTH=8 -> pointers wrap and data order is preserved across the wrap.
REQ-036 SHALL pass: load_done alone -> protocol_err=1, count unchanged; then clear with tile_valid=1 -> count=0, both flags 0.
REQ-037 SHALL pass: rst pulled low with 3 entries buffered -> out_valid=0 and count=0 immediately, without waiting for a clk edge.
